// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared arithmetic package for the serial arithmetic blocks.
// Holds the controller state encodings, the FSM state type built on them,
// and a helper that sizes a bit counter for a given operand width.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Bits needed to count 0..width-1. Never less than one bit.
  function automatic int CNT_W(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake/data bundle for the bit-serial subtractor.
//   start, a, b              : request and operands (master -> slave)
//   busy, done, diff,
//   borrow_out               : status and registered result (slave -> master)
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl_sub_bit_slice.sv
// One-bit full subtract slice: d = x - y - bin, with borrow out.
//   x, y : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// Built as two cascaded half subtractors whose borrows are ORed; the two
// borrows can never both be 1, so OR is exact.
module sub_bit_slice (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract controller: computes a - b over WIDTH cycles, LSB first,
// through a single one-bit subtract slice with the borrow held in a flop.
//   clk, rst          : clock, synchronous active-high reset
//   bus.start         : begin a subtraction (sampled in IDLE or DONE)
//   bus.a, bus.b      : operands, captured on the accepting edge
//   bus.busy          : high while the slice is iterating
//   bus.done          : one-cycle pulse when a new result is registered
//   bus.diff          : registered (a - b) mod 2^WIDTH
//   bus.borrow_out    : registered final borrow (1 when a < b)
module serial_subtractor_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_ctrl_if.slave  bus
);

  localparam int             CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, sd;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             accept;
  logic             running;
  logic             last_bit;
  logic             d_bit, bout_bit;

  sub_bit_slice u_slice (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bor),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    running  = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        running = 1'b1;
        if (cnt == CNT_LAST) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      // The unused encoding recovers to IDLE.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sd       <= '0;
      bor      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sa  <= bus.a;
        sb  <= bus.b;
        sd  <= '0;
        bor <= 1'b0;
        cnt <= '0;
      end else if (running) begin
        // New difference bit enters at the MSB so that after WIDTH shifts
        // bit 0 of the result has arrived at sd[0].
        sd  <= {d_bit, sd[WIDTH-1:1]};
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        bor <= bout_bit;
        cnt <= cnt + CW'(1);
      end
      // Result is taken from the shift input, not sd, so it is valid on the
      // same edge that processes the last bit.
      if (last_bit) begin
        diff_q   <= {d_bit, sd[WIDTH-1:1]};
        borrow_q <= bout_bit;
      end
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   overlap;

  serial_subtractor_ctrl_if #(.WIDTH(8))  bus8();
  serial_subtractor_ctrl_if #(.WIDTH(16)) bus16();

  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be seen together on either instance.
  always @(negedge clk) begin
    if ((bus8.busy && bus8.done) || (bus16.busy && bus16.done)) overlap++;
  end

  // Starts one WIDTH=8 operation from a negedge and returns at the negedge
  // where done is seen (or after a timeout). lat counts edges after the
  // accepting edge; bcy counts busy cycles observed.
  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib,
                         output int lat, output int bcy);
    bus8.start = 1'b1;
    bus8.a     = ia;
    bus8.b     = ib;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    lat = 0;
    bcy = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) bcy++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op16(input logic [15:0] ia, input logic [15:0] ib,
                          output int lat);
    bus16.start = 1'b1;
    bus16.a     = ia;
    bus16.b     = ib;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    lat = 0;
    while (!bus16.done && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b diff=%0d borrow=%b, required all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
    checks++;
    if ({bus16.busy, bus16.done, bus16.diff, bus16.borrow_out} !== 19'd0) begin
      errors++;
      $display("FAIL reset_w16: busy=%b done=%b diff=%0d borrow=%b, required all 0",
               bus16.busy, bus16.done, bus16.diff, bus16.borrow_out);
    end
  endtask

  task automatic test_basic();
    int lat, bcy;
    run_op8(8'd200, 8'd55, lat, bcy);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, required 8", lat);
    end
    checks++;
    if (bcy !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required 8", bcy);
    end
    checks++;
    if (bus8.diff !== 8'd145 || bus8.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: diff=%0d borrow=%b, required 145/0",
               bus8.diff, bus8.borrow_out);
    end
    idle_cycles(1);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.diff !== 8'd145) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b diff=%0d, required 0/0/145",
               bus8.done, bus8.busy, bus8.diff);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ta [3];
    logic [7:0] tb_ [3];
    logic [7:0] ed [3];
    logic       eb [3];
    int lat, bcy;
    ta[0] = 8'd5; tb_[0] = 8'd10;  ed[0] = 8'd251; eb[0] = 1'b1;
    ta[1] = 8'd0; tb_[1] = 8'd0;   ed[1] = 8'd0;   eb[1] = 1'b0;
    ta[2] = 8'd0; tb_[2] = 8'd255; ed[2] = 8'd1;   eb[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op8(ta[i], tb_[i], lat, bcy);
      checks++;
      if (lat !== 8 || bus8.diff !== ed[i] || bus8.borrow_out !== eb[i]) begin
        errors++;
        $display("FAIL corner_%0d: lat=%0d diff=%0d borrow=%b, required 8/%0d/%b",
                 i, lat, bus8.diff, bus8.borrow_out, ed[i], eb[i]);
      end
      idle_cycles(1);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bus8.start = 1'b1;
    bus8.a     = 8'd200;
    bus8.b     = 8'd55;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 40) begin
      if (lat == 3) begin
        bus8.start = 1'b1;
        bus8.a     = 8'd1;
        bus8.b     = 8'd2;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
    checks++;
    if (lat !== 8 || bus8.diff !== 8'd145 || bus8.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: lat=%0d diff=%0d borrow=%b, required 8/145/0",
               lat, bus8.diff, bus8.borrow_out);
    end
    idle_cycles(2);
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b done=%b, required 0/0",
               bus8.busy, bus8.done);
    end
  endtask

  task automatic test_back_to_back();
    int t, n, last;
    t = 0;
    n = 0;
    last = -1;
    overlap = 0;
    bus8.start = 1'b1;
    bus8.a     = 8'd100;
    bus8.b     = 8'd1;
    while (n < 4 && t < 60) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (bus8.done) begin
        checks++;
        if (bus8.diff !== 8'd99 || bus8.borrow_out !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result_%0d: diff=%0d borrow=%b, required 99/0",
                   n, bus8.diff, bus8.borrow_out);
        end
        if (last >= 0) begin
          checks++;
          if (t - last !== 9) begin
            errors++;
            $display("FAIL b2b_interval_%0d: got %0d cycles, required 9", n, t - last);
          end
        end
        last = t;
        n++;
      end
    end
    bus8.start = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 4", n);
    end
    idle_cycles(10);
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL b2b_busy_done_overlap: got %0d cycles, required 0", overlap);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcy, seen;
    run_op8(8'd200, 8'd55, lat, bcy);
    idle_cycles(1);
    checks++;
    if (bus8.diff !== 8'd145) begin
      errors++;
      $display("FAIL rstmid_prior: diff=%0d, required 145", bus8.diff);
    end
    bus8.start = 1'b1;
    bus8.a     = 8'd5;
    bus8.b     = 8'd10;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    idle_cycles(4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'd0 ||
        bus8.borrow_out !== 1'b0 || 2'(u8.state_q) !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_clear: busy=%b done=%b diff=%0d borrow=%b state=%0d, required all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, 2'(u8.state_q));
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done || bus8.busy) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done: %0d active cycles after reset, required 0", seen);
    end
  endtask

  task automatic test_random();
    int lat, bcy, e;
    logic [7:0]  a8, b8, ed8;
    logic [15:0] a16, b16, ed16;
    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      e   = int'(a8) - int'(b8);
      ed8 = 8'(e);
      run_op8(a8, b8, lat, bcy);
      checks++;
      if (lat !== 8 || bus8.diff !== ed8 || bus8.borrow_out !== (a8 < b8)) begin
        errors++;
        $display("FAIL rand_w8 %0d-%0d: lat=%0d diff=%0d borrow=%b, required 8/%0d/%b",
                 a8, b8, lat, bus8.diff, bus8.borrow_out, ed8, (a8 < b8));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a16  = 16'($urandom);
      b16  = (i % 50 == 0) ? a16 : 16'($urandom);
      e    = int'(a16) - int'(b16);
      ed16 = 16'(e);
      run_op16(a16, b16, lat);
      checks++;
      if (lat !== 16 || bus16.diff !== ed16 || bus16.borrow_out !== (a16 < b16)) begin
        errors++;
        $display("FAIL rand_w16 %0d-%0d: lat=%0d diff=%0d borrow=%b, required 16/%0d/%b",
                 a16, b16, lat, bus16.diff, bus16.borrow_out, ed16, (a16 < b16));
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    overlap     = 0;
    rst         = 1'b1;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
